disp_scan_mux: RTL and testbench

//  Parametrised time-multiplexed scanner for N common-anode/cathode digits sharing one

---
 rtl/disp_scan_mux.sv | 123 ++++++++++++
 tb/tb_disp_scan_mux.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/disp_scan_mux.sv
// Time-multiplexed N-digit display scanner with dead-time blanking, per-digit
// masking and frame-coherent input snapshots feeding one shared segment decoder.
module disp_scan_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIG_W        = 4,
  parameter int unsigned DWELL_CYCLES = 25000,
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic                                          IntOsc,
  input  logic                                          Reset,
  input  logic [NUM_DIGITS*DIG_W-1:0]                   DigitsIn,
  input  logic [NUM_DIGITS-1:0]                         DigitMask,
  output logic [DIG_W-1:0]                              SegInput,
  output logic [NUM_DIGITS-1:0]                         En,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] DigIdx,
  output logic                                          FrameStart
);

  localparam int unsigned IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_MAX    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam bit          HAS_BLANK  = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                        r_state, w_state_n;
  logic [IW-1:0]                 r_idx, w_idx_n;
  logic [CW-1:0]                 r_cnt, w_cnt_n;
  logic [NUM_DIGITS*DIG_W-1:0]   r_dig, w_dig_n;
  logic [NUM_DIGITS-1:0]         r_mask, w_mask_n;
  logic [DIG_W-1:0]              r_seg, w_seg_n;
  logic [NUM_DIGITS-1:0]         r_en, w_en_n;
  logic                          r_fs, w_fs_n;
  logic                          w_snap;

  always_ff @(posedge IntOsc or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_dig   <= '0;
      r_mask  <= '0;
      r_seg   <= '0;
      r_en    <= '0;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_cnt   <= w_cnt_n;
      r_dig   <= w_dig_n;
      r_mask  <= w_mask_n;
      r_seg   <= w_seg_n;
      r_en    <= w_en_n;
      r_fs    <= w_fs_n;
    end
  end

  // Next state plus outputs for the state being entered, so every output is a flop.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_cnt_n   = r_cnt + CW'(1);
    w_snap    = 1'b0;
    w_fs_n    = 1'b0;
    w_seg_n   = '0;
    w_en_n    = '0;

    unique case (r_state)
      ST_INIT: begin
        w_snap    = 1'b1;
        w_fs_n    = 1'b1;
        w_idx_n   = '0;
        w_cnt_n   = '0;
        w_state_n = HAS_BLANK ? ST_BLANK : ST_SHOW;
      end
      ST_BLANK: begin
        if (r_cnt == CW'(BLANK_LAST)) begin
          w_cnt_n   = '0;
          w_state_n = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (r_cnt == CW'(DWELL_CYCLES - 1)) begin
          w_cnt_n   = '0;
          w_state_n = HAS_BLANK ? ST_BLANK : ST_SHOW;
          if (r_idx == IW'(NUM_DIGITS - 1)) begin
            w_idx_n = '0;
            w_snap  = 1'b1;
            w_fs_n  = 1'b1;
          end else begin
            w_idx_n = r_idx + IW'(1);
          end
        end
      end
      default: begin
        w_state_n = ST_INIT;
        w_cnt_n   = '0;
      end
    endcase

    w_dig_n  = w_snap ? DigitsIn  : r_dig;
    w_mask_n = w_snap ? DigitMask : r_mask;

    // Digit value is presented during blanking too, giving the decoder setup time.
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_n == IW'(k)) begin
        w_seg_n   = w_dig_n[k*DIG_W +: DIG_W];
        w_en_n[k] = (w_state_n == ST_SHOW) && w_mask_n[k];
      end
    end
  end

  assign SegInput   = r_seg;
  assign En         = r_en;
  assign DigIdx     = r_idx;
  assign FrameStart = r_fs;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Scoreboard bench for disp_scan_mux: three instances (blanked, unblanked, single digit)
// checked cycle by cycle against a frame-position arithmetic model.
module tb_disp_scan_mux;

  typedef struct packed {
    logic [3:0] seg;
    logic [3:0] en;
    logic [1:0] idx;
    logic       fs;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic [3:0]  msk;
  logic [3:0]  din2;
  logic [0:0]  msk2;

  logic [3:0] seg0, seg1, seg2;
  logic [3:0] en0, en1;
  logic [0:0] en2;
  logic [1:0] idx0, idx1;
  logic [0:0] idx2;
  logic       fs0, fs1, fs2;

  exp_t        sb[$];
  int          n_chk;
  int          n_err;
  int          t[3];
  logic [15:0] sd[3];
  logic [3:0]  sm[3];
  int          nd[3];
  int          bl[3];
  bit          did_rst;
  int          rst_hold;

  disp_scan_mux #(.NUM_DIGITS(4), .DIG_W(4), .DWELL_CYCLES(4), .BLANK_CYCLES(1)) u_dut (
    .IntOsc(clk), .Reset(rst_n), .DigitsIn(din), .DigitMask(msk),
    .SegInput(seg0), .En(en0), .DigIdx(idx0), .FrameStart(fs0));

  disp_scan_mux #(.NUM_DIGITS(4), .DIG_W(4), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) u_dut_nb (
    .IntOsc(clk), .Reset(rst_n), .DigitsIn(din), .DigitMask(msk),
    .SegInput(seg1), .En(en1), .DigIdx(idx1), .FrameStart(fs1));

  disp_scan_mux #(.NUM_DIGITS(1), .DIG_W(4), .DWELL_CYCLES(4), .BLANK_CYCLES(1)) u_dut_one (
    .IntOsc(clk), .Reset(rst_n), .DigitsIn(din2), .DigitMask(msk2),
    .SegInput(seg2), .En(en2), .DigIdx(idx2), .FrameStart(fs2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Expected outputs after the coming edge, from position within the frame.
  task automatic push_exp(input int i, input logic [15:0] d, input logic [3:0] m);
    exp_t e;
    int   slot, p, s, w;
    e = '0;
    if (!rst_n) begin
      t[i] = 0;
    end else begin
      t[i]++;
      slot = bl[i] + 4;
      p    = (t[i] - 1) % (nd[i] * slot);
      if (p == 0) begin
        sd[i] = d;
        sm[i] = m;
      end
      s     = p / slot;
      w     = p % slot;
      e.seg = sd[i][s*4 +: 4];
      e.en  = (w >= bl[i] && sm[i][s]) ? 4'(1 << s) : 4'b0;
      e.idx = 2'(s);
      e.fs  = (p == 0);
    end
    sb.push_back(e);
  endtask

  task automatic cmp_out(input int i, input logic [3:0] seg, input logic [3:0] en,
                         input logic [1:0] idx, input logic fs);
    exp_t e;
    if (sb.size() == 0) begin
      chk($sformatf("sb_underflow%0d", i), 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("seg%0d", i), 32'(seg), 32'(e.seg));
    chk($sformatf("en%0d", i),  32'(en),  32'(e.en));
    chk($sformatf("idx%0d", i), 32'(idx), 32'(e.idx));
    chk($sformatf("fs%0d", i),  32'(fs),  32'(e.fs));
    chk($sformatf("onehot%0d", i), 32'($countones(en) <= 1), 32'd1);
  endtask

  initial begin
    n_chk = 0; n_err = 0; did_rst = 1'b0; rst_hold = 0;
    nd = '{4, 4, 1};
    bl = '{1, 0, 1};
    foreach (t[i]) begin t[i] = 0; sd[i] = '0; sm[i] = '0; end
    din = 16'h4321; msk = 4'hF; din2 = 4'h0; msk2 = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      if (c == 2) rst_n = 1'b1;
      if (c == 10) din = 16'hABCD;
      if (c == 60) msk = 4'b0101;
      if (c >= 120) begin
        din = 16'($urandom);
        msk = 4'($urandom);
      end
      din2 = 4'($urandom);
      msk2 = 1'($urandom);
      // Asynchronous reset in the middle of digit 2's display window.
      if (c >= 150 && !did_rst && rst_n && ((t[0] - 1) % 20) == 12) begin
        chk("pre_rst_en", 32'(en0), 32'(sm[0][2] ? 4'b0100 : 4'b0000));
        rst_n = 1'b0;
        #1;
        chk("rst_seg0", 32'(seg0), 32'd0);
        chk("rst_en0",  32'(en0),  32'd0);
        chk("rst_idx0", 32'(idx0), 32'd0);
        chk("rst_fs0",  32'(fs0),  32'd0);
        chk("rst_en1",  32'(en1),  32'd0);
        chk("rst_seg2", 32'(seg2), 32'd0);
        did_rst  = 1'b1;
        rst_hold = c + 2;
      end
      if (did_rst && c == rst_hold) rst_n = 1'b1;
      push_exp(0, din, msk);
      push_exp(1, din, msk);
      push_exp(2, {12'h000, din2}, {3'b000, msk2});
      @(posedge clk);
      #1;
      cmp_out(0, seg0, en0, idx0, fs0);
      cmp_out(1, seg1, en1, idx1, fs1);
      cmp_out(2, seg2, {3'b000, en2}, {1'b0, idx2}, fs2);
    end
    chk("mid_reset_hit", 32'(did_rst), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
